// File: rtl/exp3_pkg.sv
// Shared definitions for the Exp3 control unit: state codes, output bundle
// and the Moore decode from state to datapath/status controls.
package exp3_pkg;

  localparam int TIMEOUT_DEFAULT = 5000;

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARA     = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARA     = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTO  = 4'b1010,
    FIM_ERRO    = 4'b1110,
    FIM_TIMEOUT = 4'b1101
  } estado_t;

  typedef struct packed {
    logic zera;
    logic conta;
    logic registra;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  function automatic saidas_t decodifica(estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARA:     s.zera     = 1'b1;
      REGISTRA:    s.registra = 1'b1;
      PROXIMO:     s.conta    = 1'b1;
      FIM_ACERTO:  begin s.pronto = 1'b1; s.acertou = 1'b1; end
      FIM_ERRO:    begin s.pronto = 1'b1; s.errou   = 1'b1; end
      FIM_TIMEOUT: begin s.pronto = 1'b1; s.errou = 1'b1; s.timeout = 1'b1; end
      default:     s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_exp3_edge_detector.sv
// Rising-edge detector for the move button: a two-sample history register
// (current and previous sample) feeding a single AND gate.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic [1:0] hist_q;
  logic [1:0] hist_d;

  always_comb begin
    hist_d = {hist_q[0], sinal};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= 2'b00;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Pulse while the newest sample is 1 and the one before it was 0.
  assign pulso = hist_q[0] & ~hist_q[1];

endmodule

// File: rtl/unidade_controle_exp3.sv
// Moore control unit for the Exp3 game round: clear, wait for a move,
// register, compare, advance; ends in hit, miss or timeout.
module unidade_controle_exp3
  import exp3_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = $clog2(TIMEOUT)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zera,
  output logic       conta,
  output logic       registra,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam logic [TW-1:0] ULTIMO = TW'(TIMEOUT - 1);

  estado_t       estado_q, estado_d;
  logic [TW-1:0] cnt_q, cnt_d;
  saidas_t       saidas_q, saidas_d;
  logic          jog_p;

  edge_detector u_edge (
    .clock (clock),
    .reset (reset),
    .sinal (jogada),
    .pulso (jog_p)
  );

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARA;
      end
      PREPARA: begin
        estado_d = ESPERA;
        cnt_d    = '0;
      end
      ESPERA: begin
        // Saturating at ULTIMO keeps the counter from wrapping on a jog_p tie.
        if (cnt_q != ULTIMO) cnt_d = cnt_q + 1'b1;
        if (jog_p)                estado_d = REGISTRA;
        else if (cnt_q == ULTIMO) estado_d = FIM_TIMEOUT;
      end
      REGISTRA: begin
        estado_d = COMPARA;
      end
      COMPARA: begin
        if (!igual)   estado_d = FIM_ERRO;
        else if (fim) estado_d = FIM_ACERTO;
        else          estado_d = PROXIMO;
      end
      PROXIMO: begin
        estado_d = ESPERA;
        cnt_d    = '0;
      end
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) estado_d = PREPARA;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase
    // Outputs are decoded from the next state so they register in step with it.
    saidas_d = decodifica(estado_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      cnt_q    <= '0;
      saidas_q <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      saidas_q <= saidas_d;
    end
  end

  assign zera      = saidas_q.zera;
  assign conta     = saidas_q.conta;
  assign registra  = saidas_q.registra;
  assign pronto    = saidas_q.pronto;
  assign acertou   = saidas_q.acertou;
  assign errou     = saidas_q.errou;
  assign timeout   = saidas_q.timeout;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_exp3.sv
// Bench for unidade_controle_exp3: directed round scenarios plus random
// stimulus, all checked every cycle against a round-level reference model.
module tb_unidade_controle_exp3;

  localparam int TIMEOUT = 8;
  localparam int NPOS    = 4;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada, igual, fim;
  logic       zera, conta, registra, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  unidade_controle_exp3 #(.TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fim       (fim),
    .zera      (zera),
    .conta     (conta),
    .registra  (registra),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Round phases of the reference model (bench-local numbering).
  localparam int P_INI = 0, P_PREP = 1, P_WAIT = 2, P_REG = 3, P_CMP = 4,
                 P_NEXT = 5, P_HIT = 6, P_MISS = 7, P_TOUT = 8;

  int   m_ph = P_INI;
  int   m_elapsed = 0;
  logic m_now = 1'b0, m_before = 1'b0;
  bit   m_valid = 1'b0;
  int   dp_pos = 0;
  int   n_zera = 0, n_conta = 0, n_reg = 0;

  // {db_estado, zera, conta, registra, pronto, acertou, errou, timeout}
  function automatic logic [10:0] expected(int ph);
    case (ph)
      P_PREP: return {4'b0001, 7'b1000000};
      P_WAIT: return {4'b0010, 7'b0000000};
      P_REG:  return {4'b0100, 7'b0010000};
      P_CMP:  return {4'b0101, 7'b0000000};
      P_NEXT: return {4'b0110, 7'b0100000};
      P_HIT:  return {4'b1010, 7'b0001100};
      P_MISS: return {4'b1110, 7'b0001010};
      P_TOUT: return {4'b1101, 7'b0001011};
      default: return 11'b0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endtask

  // One clock: apply inputs, advance the datapath and the model, compare.
  task automatic tick(input logic r, input logic i, input logic j, input logic g);
    logic z_pre, c_pre, f_app, pulse;
    reset   = r;
    iniciar = i;
    jogada  = j;
    igual   = g;
    fim     = (dp_pos == NPOS - 1);
    f_app   = fim;
    z_pre   = zera;
    c_pre   = conta;
    @(posedge clock);
    if (z_pre === 1'b1)      dp_pos = 0;
    else if (c_pre === 1'b1) dp_pos++;
    if (r) begin
      m_ph = P_INI; m_elapsed = 0; m_now = 1'b0; m_before = 1'b0;
      m_valid = 1'b1;
    end else begin
      pulse    = m_now & ~m_before;
      m_before = m_now;
      m_now    = j;
      case (m_ph)
        P_INI:  if (i) m_ph = P_PREP;
        P_PREP: begin m_ph = P_WAIT; m_elapsed = 0; end
        P_WAIT: begin
          m_elapsed++;
          if (pulse) m_ph = P_REG;
          else if (m_elapsed == TIMEOUT) m_ph = P_TOUT;
        end
        P_REG:  m_ph = P_CMP;
        P_CMP:  m_ph = !g ? P_MISS : (f_app ? P_HIT : P_NEXT);
        P_NEXT: begin m_ph = P_WAIT; m_elapsed = 0; end
        default: if (i) m_ph = P_PREP;
      endcase
    end
    #1;
    if (m_valid)
      check("outputs", {21'b0, db_estado, zera, conta, registra, pronto, acertou, errou, timeout},
            {21'b0, expected(m_ph)});
    n_zera  += int'(zera === 1'b1);
    n_conta += int'(conta === 1'b1);
    n_reg   += int'(registra === 1'b1);
    @(negedge clock);
  endtask

  task automatic move(input logic g);
    tick(0, 0, 1, g);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, g);
  endtask

  initial begin
    logic jr;
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b1; fim = 1'b0;
    @(negedge clock);

    // Reset state
    tick(1, 0, 0, 1);
    check("reset_db", db_estado, 4'b0000);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    check("idle_db", db_estado, 4'b0000);

    // Full hit over four positions
    n_zera = 0; n_conta = 0; n_reg = 0;
    tick(0, 1, 0, 1);
    tick(0, 0, 0, 1);
    for (int m = 0; m < NPOS; m++) move(1'b1);
    check("hit_db", db_estado, 4'b1010);
    check("hit_acertou", acertou, 1);
    check("hit_pronto", pronto, 1);
    check("hit_conta_pulses", n_conta, 3);
    check("hit_registra_pulses", n_reg, 4);
    check("hit_zera_pulses", n_zera, 1);

    // Miss on second move
    n_conta = 0;
    tick(0, 1, 0, 1);
    tick(0, 0, 0, 1);
    move(1'b1);
    move(1'b0);
    check("miss_db", db_estado, 4'b1110);
    check("miss_errou", errou, 1);
    check("miss_acertou", acertou, 0);
    check("miss_conta_pulses", n_conta, 1);

    // Restart from FIM_ERRO, then timeout with no move
    tick(0, 1, 0, 1);
    check("restart_zera", zera, 1);
    check("restart_db", db_estado, 4'b0001);
    tick(0, 0, 0, 1);
    check("restart_wait_db", db_estado, 4'b0010);
    for (int k = 0; k < TIMEOUT - 1; k++) tick(0, 0, 0, 1);
    check("pre_timeout_db", db_estado, 4'b0010);
    tick(0, 0, 0, 1);
    check("timeout_db", db_estado, 4'b1101);
    check("timeout_flag", timeout, 1);
    check("timeout_errou", errou, 1);

    // Held button: exactly one registra
    tick(0, 1, 0, 1);
    n_reg = 0;
    for (int k = 0; k < 20; k++) tick(0, 0, 1, 1);
    check("held_registra_pulses", n_reg, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);

    // Move pulse coinciding with the last timeout count
    tick(0, 1, 0, 1);
    tick(0, 0, 0, 1);
    for (int k = 0; k < TIMEOUT - 2; k++) tick(0, 0, 0, 1);
    tick(0, 0, 1, 1);
    check("tie_pre_db", db_estado, 4'b0010);
    tick(0, 0, 0, 1);
    check("tie_db", db_estado, 4'b0100);
    check("tie_registra", registra, 1);

    // Reset mid-round
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 1);
    check("midround_db", db_estado, 4'b0010);
    tick(1, 0, 0, 1);
    check("midreset_db", db_estado, 4'b0000);
    check("midreset_outs", {zera, conta, registra, pronto, acertou, errou, timeout}, 7'b0);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 1);
    check("midreset_idle_db", db_estado, 4'b0000);

    // Random rounds
    jr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) jr = ~jr;
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), jr,
           ($urandom_range(0, 5) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
